// File: rtl/fir_mac_decim_if.sv
// Sample/coefficient bus for fir_mac_decim: input handshake, coefficient port,
// flush and output strobe grouped so source and filter share one connection.
interface fir_mac_decim_if #(
  parameter int WIDTH      = 16,
  parameter int COEF_WIDTH = 16,
  parameter int TAPS       = 17
);
  localparam int AW = (TAPS > 1) ? $clog2(TAPS) : 1;

  logic                         flush_i;
  logic                         coef_we_i;
  logic [AW-1:0]                coef_addr_i;
  logic signed [COEF_WIDTH-1:0] coef_data_i;
  logic                         in_valid_i;
  logic                         in_ready_o;
  logic signed [WIDTH-1:0]      data_i;
  logic                         out_valid_o;
  logic signed [WIDTH-1:0]      data_o;

  modport master (
    output flush_i, coef_we_i, coef_addr_i, coef_data_i, in_valid_i, data_i,
    input  in_ready_o, out_valid_o, data_o
  );

  modport slave (
    input  flush_i, coef_we_i, coef_addr_i, coef_data_i, in_valid_i, data_i,
    output in_ready_o, out_valid_o, data_o
  );
endinterface

// File: rtl/fir_mac_decim.sv
// Time-multiplexed FIR low-pass with optional decimation: one signed MAC walks
// the TAPS products serially, then rounds and saturates into a one-cycle strobe.
module fir_mac_decim #(
  parameter int WIDTH      = 16,
  parameter int COEF_WIDTH = 16,
  parameter int TAPS       = 17,
  parameter int DECIM      = 1
) (
  input logic            clk,
  input logic            rst,
  fir_mac_decim_if.slave bus
);
  localparam int ACC_W = WIDTH + COEF_WIDTH + $clog2(TAPS);
  localparam int AW    = $clog2(TAPS);
  localparam int PW    = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int PRW   = WIDTH + COEF_WIDTH;
  localparam int F     = COEF_WIDTH - 1;
  localparam int RW    = ACC_W - F;

  localparam logic signed [ACC_W-1:0] RND_HALF = {{(ACC_W-1){1'b0}}, 1'b1} << (F - 1);
  localparam logic signed [RW-1:0]    R_MAX    = {{(RW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [RW-1:0]    R_MIN    = {{(RW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  state_t                    state_q, state_d;
  logic [PW-1:0]             phase_q, phase_d;
  logic [AW-1:0]             idx_q, idx_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [WIDTH-1:0]   data_q, data_d;
  logic signed [WIDTH-1:0]   buff_q [TAPS];
  logic signed [COEF_WIDTH-1:0] coef_q [TAPS];

  logic                      in_ready_w, accept_w, out_fire_w, coef_wr_w;
  logic signed [PRW-1:0]     prod_w;
  logic signed [ACC_W-1:0]   prod_ext_w;
  logic signed [WIDTH-1:0]   out_val_w;

  function automatic logic signed [RW-1:0] round_acc(input logic signed [ACC_W-1:0] a);
    return RW'((a + RND_HALF) >>> F);
  endfunction

  function automatic logic signed [WIDTH-1:0] saturate(input logic signed [RW-1:0] r);
    if (r > R_MAX)      return {1'b0, {(WIDTH-1){1'b1}}};
    else if (r < R_MIN) return {1'b1, {(WIDTH-1){1'b0}}};
    else                return r[WIDTH-1:0];
  endfunction

  assign in_ready_w = (state_q == S_IDLE);
  assign accept_w   = bus.in_valid_i & in_ready_w & ~bus.flush_i;
  assign out_fire_w = (state_q == S_OUT) & ~bus.flush_i;
  // Coefficients may only change while no computation is reading them.
  assign coef_wr_w  = bus.coef_we_i & in_ready_w & (int'(bus.coef_addr_i) < TAPS);

  assign prod_w     = coef_q[idx_q] * buff_q[idx_q];
  assign prod_ext_w = {{(ACC_W-PRW){prod_w[PRW-1]}}, prod_w};
  assign out_val_w  = saturate(round_acc(acc_q));

  assign bus.in_ready_o  = in_ready_w;
  assign bus.out_valid_o = out_fire_w;
  assign bus.data_o      = out_fire_w ? out_val_w : data_q;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    data_d  = data_q;
    if (out_fire_w) data_d = out_val_w;
    if (bus.flush_i) begin
      state_d = S_IDLE;
      phase_d = '0;
      idx_d   = '0;
      acc_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_w) begin
            if (phase_q == PW'(DECIM - 1)) begin
              phase_d = '0;
              acc_d   = '0;
              idx_d   = '0;
              state_d = S_MAC;
            end else begin
              phase_d = phase_q + 1'b1;
            end
          end
        end
        S_MAC: begin
          acc_d = acc_q + prod_ext_w;
          idx_d = idx_q + 1'b1;
          if (idx_q == AW'(TAPS - 1)) begin
            idx_d   = '0;
            state_d = S_OUT;
          end
        end
        S_OUT:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
    end
  end

  // Delay line (index 0 = newest sample) and coefficient store.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) begin
        buff_q[k] <= '0;
        coef_q[k] <= '0;
      end
    end else begin
      if (bus.flush_i) begin
        for (int k = 0; k < TAPS; k++) buff_q[k] <= '0;
      end else if (accept_w) begin
        buff_q[0] <= bus.data_i;
        for (int k = 1; k < TAPS; k++) buff_q[k] <= buff_q[k-1];
      end
      if (coef_wr_w) coef_q[bus.coef_addr_i] <= bus.coef_data_i;
    end
  end
endmodule
